// File: rtl/mem_ctrl_seq.sv
// Sequencer between the CPU load/store port and a single-port synchronous data RAM.
// One request per handshake; RAM enables pulse for one cycle, then a fixed wait, then Done.
module mem_ctrl_seq #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 8,
    parameter int MEMDEPTH    = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Valid,
    input  logic                  RW,
    input  logic [AWIDTH-1:0]     Addr_in,
    input  logic [DWIDTH-1:0]     Wdata_in,
    input  logic [DWIDTH/8-1:0]   BE_in,
    output logic                  Ready,
    output logic                  Done,
    output logic                  Err,
    output logic [DWIDTH-1:0]     Rdata_out,
    output logic                  rdEn,
    output logic                  wrEn,
    output logic [DWIDTH/8-1:0]   wrByteEn,
    output logic [AWIDTH-1:0]     Addr,
    output logic [DWIDTH-1:0]     Wdata,
    input  logic [DWIDTH-1:0]     Rdata
);
    localparam int NBE = DWIDTH / 8;
    localparam int CW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
    // One extra bit so MEMDEPTH == 2^AWIDTH is representable
    localparam logic [AWIDTH:0] DEPTH_LIM = (AWIDTH + 1)'(MEMDEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                rw_q, rw_d;
    logic                err_q, err_d;
    logic [NBE-1:0]      be_q, be_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            err_q   <= err_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        err_d   = err_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (Valid) begin
                    addr_d  = Addr_in;
                    wdata_d = Wdata_in;
                    be_d    = BE_in;
                    rw_d    = RW;
                    if ({1'b0, Addr_in} < DEPTH_LIM) begin
                        err_d   = 1'b0;
                        state_d = S_ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCESS: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (rw_q) begin
                        rdata_d = Rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake and RAM strobes come only from registered state
    assign Ready     = (state_q == S_IDLE);
    assign Done      = (state_q == S_DONE);
    assign Err       = (state_q == S_DONE) && err_q;
    assign rdEn      = (state_q == S_ACCESS) && rw_q;
    assign wrEn      = (state_q == S_ACCESS) && !rw_q;
    assign wrByteEn  = wrEn ? be_q : '0;
    assign Addr      = addr_q;
    assign Wdata     = wdata_q;
    assign Rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_ctrl_seq.sv
// Bench for mem_ctrl_seq: two instances (MEMDEPTH=200/WAIT=2 and MEMDEPTH=256/WAIT=1)
// share one stimulus stream; each has its own RAM model and transaction-level reference.
module tb_mem_ctrl_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, valid, rw;
    logic [7:0]  addr_in;
    logic [31:0] wdata_in;
    logic [3:0]  be_in;

    logic        ready [2], done [2], err [2], rden [2], wren [2];
    logic [3:0]  wbe [2];
    logic [7:0]  addr_o [2];
    logic [31:0] wdata_o [2], rdout [2], ram_rdata [2];

    mem_ctrl_seq #(.MEMDEPTH(200), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .Valid(valid), .RW(rw), .Addr_in(addr_in),
        .Wdata_in(wdata_in), .BE_in(be_in), .Ready(ready[0]), .Done(done[0]),
        .Err(err[0]), .Rdata_out(rdout[0]), .rdEn(rden[0]), .wrEn(wren[0]),
        .wrByteEn(wbe[0]), .Addr(addr_o[0]), .Wdata(wdata_o[0]), .Rdata(ram_rdata[0]));

    mem_ctrl_seq #(.MEMDEPTH(256), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Valid(valid), .RW(rw), .Addr_in(addr_in),
        .Wdata_in(wdata_in), .BE_in(be_in), .Ready(ready[1]), .Done(done[1]),
        .Err(err[1]), .Rdata_out(rdout[1]), .rdEn(rden[1]), .wrEn(wren[1]),
        .wrByteEn(wbe[1]), .Addr(addr_o[1]), .Wdata(wdata_o[1]), .Rdata(ram_rdata[1]));

    function automatic int wc_of(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int depth_of(int d);
        return (d == 0) ? 200 : 256;
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // RAM models and the DUT strobes sampled in the previous cycle
    logic [31:0] ram [2][256];
    logic        s_rd [2], s_wr [2];
    logic [3:0]  s_be [2];
    logic [7:0]  s_a [2];
    logic [31:0] s_wd [2];

    // Reference: m_c counts cycles since acceptance (0 = idle), m_len is the busy length
    int          m_c [2], m_len [2];
    logic        m_inr [2], m_rw [2];
    logic [7:0]  m_addr [2];
    logic [31:0] m_wd [2], m_rdo [2];
    logic [3:0]  m_be [2];
    logic [31:0] mem [2][256];

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d got %h exp %h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_c[d] = 0; m_addr[d] = '0; m_wd[d] = '0; m_rdo[d] = '0; m_be[d] = '0;
            end else if (m_c[d] == 0) begin
                if (valid) begin
                    m_addr[d] = addr_in; m_wd[d] = wdata_in; m_be[d] = be_in; m_rw[d] = rw;
                    m_inr[d]  = int'(addr_in) < depth_of(d);
                    m_len[d]  = m_inr[d] ? wc_of(d) + 2 : 1;
                    m_c[d]    = 1;
                    if (m_inr[d] && !rw)
                        for (int b = 0; b < 4; b++)
                            if (be_in[b]) mem[d][addr_in][8*b +: 8] = wdata_in[8*b +: 8];
                end
            end else begin
                m_c[d] = (m_c[d] == m_len[d]) ? 0 : m_c[d] + 1;
            end
            if (m_c[d] != 0 && m_c[d] == m_len[d] && m_inr[d] && m_rw[d])
                m_rdo[d] = mem[d][m_addr[d]];
        end
    endtask

    task automatic check_outputs();
        logic e_done, e_rd, e_wr;
        for (int d = 0; d < 2; d++) begin
            e_done = (m_c[d] != 0) && (m_c[d] == m_len[d]);
            e_rd   = (m_c[d] == 1) && m_inr[d] && m_rw[d];
            e_wr   = (m_c[d] == 1) && m_inr[d] && !m_rw[d];
            chk("ready", d, ready[d], m_c[d] == 0);
            chk("done", d, done[d], e_done);
            chk("err", d, err[d], e_done && !m_inr[d]);
            chk("rden", d, rden[d], e_rd);
            chk("wren", d, wren[d], e_wr);
            chk("wbe", d, wbe[d], e_wr ? m_be[d] : 4'h0);
            chk("addr", d, addr_o[d], m_addr[d]);
            chk("wdata", d, wdata_o[d], m_wd[d]);
            chk("rdata_out", d, rdout[d], m_rdo[d]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (s_rd[d]) ram_rdata[d] <= ram[d][s_a[d]];
            if (s_wr[d])
                for (int b = 0; b < 4; b++)
                    if (s_be[d][b]) ram[d][s_a[d]][8*b +: 8] = s_wd[d][8*b +: 8];
        end
        model_step();
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            s_rd[d] = rden[d]; s_wr[d] = wren[d]; s_be[d] = wbe[d];
            s_a[d] = addr_o[d]; s_wd[d] = wdata_o[d];
        end
        check_outputs();
    endtask

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        exp_err;
        int          exp_lat;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    function automatic vec_t mk(logic r, logic [7:0] a, logic [31:0] w, logic [3:0] b,
                                logic e, logic c, logic [31:0] x);
        vec_t v;
        v.rw = r; v.addr = a; v.wd = w; v.be = b; v.exp_err = e;
        v.exp_lat = e ? 1 : 4; v.chk_rd = c; v.exp_rd = x;
        return v;
    endfunction

    // Request on dut0: wait for Ready, hold Valid for the accepting edge, measure to Done
    task automatic do_req(input vec_t v, input int idx);
        int n, nrd, nwr;
        n = 0;
        while (!ready[0] && n < 20) begin tick(); n++; end
        chk($sformatf("v%0d_ready", idx), 0, ready[0], 1'b1);
        valid = 1'b1; rw = v.rw; addr_in = v.addr; wdata_in = v.wd; be_in = v.be;
        tick();
        valid = 1'b0; wdata_in = $urandom; addr_in = 8'($urandom);
        n = 1; nrd = 0; nwr = 0;
        forever begin
            nrd += int'(rden[0]);
            nwr += int'(wren[0]);
            if (done[0] || n >= 20) break;
            tick();
            n++;
        end
        chk($sformatf("v%0d_done", idx), 0, done[0], 1'b1);
        chk($sformatf("v%0d_latency", idx), 0, n, v.exp_lat);
        chk($sformatf("v%0d_err", idx), 0, err[0], v.exp_err);
        chk($sformatf("v%0d_addr", idx), 0, addr_o[0], v.addr);
        chk($sformatf("v%0d_rd_pulses", idx), 0, nrd, (!v.exp_err && v.rw) ? 1 : 0);
        chk($sformatf("v%0d_wr_pulses", idx), 0, nwr, (!v.exp_err && !v.rw) ? 1 : 0);
        if (v.chk_rd) chk($sformatf("v%0d_rdata", idx), 0, rdout[0], v.exp_rd);
    endtask

    vec_t tbl [15];
    int   last [2], ndone [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a++) begin ram[d][a] = '0; mem[d][a] = '0; end
            s_rd[d] = 0; s_wr[d] = 0; s_be[d] = '0; s_a[d] = '0; s_wd[d] = '0;
            m_c[d] = 0; m_len[d] = 1; m_inr[d] = 0; m_rw[d] = 0;
            m_addr[d] = '0; m_wd[d] = '0; m_rdo[d] = '0; m_be[d] = '0;
        end
        tbl[0]  = mk(1'b0, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0);
        tbl[1]  = mk(1'b1, 8'h10, 32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEEF);
        tbl[2]  = mk(1'b0, 8'h10, 32'h000000AA, 4'h1, 1'b0, 1'b0, 32'h0);
        tbl[3]  = mk(1'b1, 8'h10, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEAA);
        tbl[4]  = mk(1'b1, 8'hF0, 32'h0,        4'h0, 1'b1, 1'b1, 32'hDEADBEAA);
        tbl[5]  = mk(1'b0, 8'hC7, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'h0);
        tbl[6]  = mk(1'b1, 8'hC7, 32'h0,        4'h0, 1'b0, 1'b1, 32'h12345678);
        tbl[7]  = mk(1'b0, 8'hC8, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'h0);
        tbl[8]  = mk(1'b0, 8'h20, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0);
        tbl[9]  = mk(1'b0, 8'h20, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0, 32'h0);
        tbl[10] = mk(1'b1, 8'h20, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11223344);
        tbl[11] = mk(1'b0, 8'h10, 32'hA5A5A5A5, 4'hA, 1'b0, 1'b0, 32'h0);
        tbl[12] = mk(1'b1, 8'h10, 32'h0,        4'h0, 1'b0, 1'b1, 32'hA5ADA5AA);
        tbl[13] = mk(1'b1, 8'hC8, 32'h0,        4'h0, 1'b1, 1'b1, 32'hA5ADA5AA);
        tbl[14] = mk(1'b1, 8'h00, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000);

        rst_n = 1'b0; valid = 1'b1; rw = 1'b1; addr_in = 8'h10; wdata_in = '0; be_in = '0;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", d, ready[d], 1'b1);
            chk("rst_rden", d, rden[d], 1'b0);
            chk("rst_wren", d, wren[d], 1'b0);
            chk("rst_done", d, done[d], 1'b0);
            chk("rst_err", d, err[d], 1'b0);
            chk("rst_rdata_out", d, rdout[d], 32'h0);
        end
        valid = 1'b0;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) do_req(tbl[i], i);

        // Reset during WAIT of a read: no Done afterwards, controller idle
        begin
            int n;
            n = 0;
            while (!ready[0] && n < 20) begin tick(); n++; end
            valid = 1'b1; rw = 1'b1; addr_in = 8'hC7;
            tick();
            valid = 1'b0;
            tick();
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            chk("midrst_ready", 0, ready[0], 1'b1);
            chk("midrst_done", 0, done[0], 1'b0);
            chk("midrst_rdata_out", 0, rdout[0], 32'h0);
            tick();
            chk("midrst_no_late_done", 0, done[0], 1'b0);
            do_req(mk(1'b1, 8'hC7, 32'h0, 4'h0, 1'b0, 1'b1, 32'h12345678), 99);
        end

        // Valid held high with alternating RW: spacing is WAIT_CYCLES+3
        begin
            int n;
            n = 0;
            while (!(ready[0] && ready[1]) && n < 20) begin tick(); n++; end
            valid = 1'b1; rw = 1'b0; addr_in = 8'($urandom_range(0, 199));
            for (int d = 0; d < 2; d++) begin last[d] = -1; ndone[d] = 0; end
            for (int k = 0; k < 40; k++) begin
                tick();
                rw = ~rw;
                addr_in  = 8'($urandom_range(0, 199));
                wdata_in = $urandom;
                be_in    = 4'($urandom);
                for (int d = 0; d < 2; d++) begin
                    if (done[d]) begin
                        if (last[d] >= 0) chk("tp_spacing", d, cyc - last[d], wc_of(d) + 3);
                        last[d] = cyc;
                        ndone[d]++;
                    end
                end
            end
            valid = 1'b0;
            chk("tp_count", 0, ndone[0] >= 7, 1'b1);
            chk("tp_count", 1, ndone[1] >= 9, 1'b1);
        end

        for (int k = 0; k < 400; k++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            valid    = ($urandom_range(0, 3) != 0);
            rw       = 1'($urandom);
            addr_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255))
                                                   : 8'($urandom_range(0, 63));
            wdata_in = $urandom;
            be_in    = 4'($urandom);
            tick();
        end
        rst_n = 1'b1;
        valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
